// File: rtl/master_full_pkg.sv
// master_full_pkg: shared frame geometry, defaults, FSM states and frame packing helper.
package master_full_pkg;
   localparam int DEF_FRAME_W = 392;
   localparam int DEF_CLK_DIV = 2;
   localparam int TEXT_MSB    = 391;
   localparam int TEXT_LSB    = 264;
   localparam int KSIZE_MSB   = 263;
   localparam int KSIZE_LSB   = 256;
   localparam int KEY_MSB     = 255;
   localparam int KEY_LSB     = 0;
   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
   function automatic logic [DEF_FRAME_W-1:0] make_frame(input logic [127:0] text,
                                                          input logic [7:0] ksize,
                                                          input logic [255:0] key);
      logic [DEF_FRAME_W-1:0] f;
      f = '0;
      f[TEXT_MSB:TEXT_LSB]   = text;
      f[KSIZE_MSB:KSIZE_LSB] = ksize;
      f[KEY_MSB:KEY_LSB]     = key;
      return f;
   endfunction
endpackage

// File: rtl/master_full_if.sv
// master_full_if: frame request/result and SPI pins between controller and its user/slave.
interface master_full_if import master_full_pkg::*; #(parameter int FRAME_W = DEF_FRAME_W) ();
   logic               start;
   logic [FRAME_W-1:0] data_in;
   logic [FRAME_W-1:0] data_out;
   logic               buzy;
   logic               done;
   logic               cs;
   logic               sclk;
   logic               mosi;
   logic               miso;
   modport master(input start, data_in, miso, output buzy, done, data_out, cs, sclk, mosi);
   modport slave(output start, data_in, miso, input buzy, done, data_out, cs, sclk, mosi);
endinterface

// File: rtl/master_full_spi_sclk_gen.sv
// spi_sclk_gen: divides clk into a mode-0 sclk and flags the clk edge on which sclk toggles.
module spi_sclk_gen #(parameter int CLK_DIV = 2) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   output logic o_sclk,
   output logic o_rise_pulse,
   output logic o_fall_pulse
);
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   logic [DW-1:0] r_div;
   logic          r_sclk;
   logic          w_tc;
   assign w_tc = i_en && r_div == DW'(CLK_DIV - 1);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div  <= '0;
         r_sclk <= 1'b0;
      end else if (!i_en) begin
         r_div  <= '0;
         r_sclk <= 1'b0;
      end else if (w_tc) begin
         r_div  <= '0;
         r_sclk <= ~r_sclk;
      end else begin
         r_div  <= r_div + 1'b1;
      end
   end
   // pulses mark the edge at which sclk is about to toggle, so the datapath acts in step with it
   assign o_sclk       = r_sclk;
   assign o_rise_pulse = w_tc && !r_sclk;
   assign o_fall_pulse = w_tc && r_sclk;
endmodule

// File: rtl/master_full.sv
// master_full: SPI mode-0 master shifting one FRAME_W-bit frame MSB first, full duplex.
module master_full
   import master_full_pkg::*;
#(
   parameter int FRAME_W = DEF_FRAME_W,
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input logic            clk,
   input logic            reset,
   master_full_if.master  bus
);
   localparam int CW = $clog2(FRAME_W);
   state_t             r_state, w_next;
   logic [FRAME_W-1:0] r_tx, r_rx, r_data_out;
   logic [CW-1:0]      r_bit_cnt;
   logic               w_sclk, w_rise, w_fall, w_last, w_load;
   logic               w_cs, w_buzy, w_done, w_mosi;
   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
      .clk          (clk),
      .reset        (reset),
      .i_en         (r_state == XFER),
      .o_sclk       (w_sclk),
      .o_rise_pulse (w_rise),
      .o_fall_pulse (w_fall)
   );
   assign w_last = r_state == XFER && w_fall && r_bit_cnt == CW'(FRAME_W - 1);
   assign w_load = r_state != XFER && bus.start;
   always_comb begin
      w_next = r_state;
      if (r_state == XFER) begin
         if (w_last) w_next = DONE;
      end else if (bus.start) w_next = XFER;
      else w_next = IDLE;
      w_cs   = r_state != XFER;
      w_buzy = r_state == XFER;
      w_done = r_state == DONE;
      w_mosi = w_buzy & r_tx[FRAME_W-1];
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_tx       <= '0;
         r_rx       <= '0;
         r_data_out <= '0;
         r_bit_cnt  <= '0;
      end else begin
         r_state <= w_next;
         if (w_load) begin
            r_tx      <= bus.data_in;
            r_rx      <= '0;
            r_bit_cnt <= '0;
         end else if (r_state == XFER) begin
            if (w_rise) r_rx <= {r_rx[FRAME_W-2:0], bus.miso};
            // the last falling edge ends the frame instead of shifting past the final bit
            if (w_fall && !w_last) begin
               r_tx      <= r_tx << 1;
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_last) r_data_out <= r_rx;
         end
      end
   end
   assign bus.cs       = w_cs;
   assign bus.sclk     = w_sclk;
   assign bus.mosi     = w_mosi;
   assign bus.buzy     = w_buzy;
   assign bus.done     = w_done;
   assign bus.data_out = r_data_out;
endmodule

// File: tb/tb_master_full.sv
// tb_master_full: directed checks of frame timing, loopback, fixed/patterned miso, back-to-back and reset abort.
module tb_master_full;
   import master_full_pkg::*;
   localparam int FW = DEF_FRAME_W;
   localparam int XFER_CYC = 2 * DEF_CLK_DIV * DEF_FRAME_W;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   int            n_tests = 0;
   int            n_fail = 0;
   int            rises = 0, cs_low = 0, dones = 0;
   logic          prev_sclk = 1'b0;
   int            mode = 0;
   logic          cval = 1'b0;
   logic [FW-1:0] pat = '0;
   int            rbase = 0;
   int            pidx;

   master_full_if bus ();
   master_full dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   assign pidx = FW - 1 - (rises - rbase);
   assign bus.miso = mode == 0 ? bus.mosi : mode == 1 ? cval : (pidx >= 0 && pidx < FW) ? pat[pidx] : 1'b0;

   always @(negedge clk) begin
      if (bus.sclk && !prev_sclk) rises <= rises + 1;
      if (!bus.cs) cs_low <= cs_low + 1;
      if (bus.done) dones <= dones + 1;
      prev_sclk <= bus.sclk;
   end

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag);
      bit got;
      got = 0;
      for (int i = 0; i < XFER_CYC + 100 && !got; i++) begin
         @(negedge clk);
         got = bus.done;
      end
      chk(tag, FW'(got), FW'(1));
   endtask

   task automatic pulse_start(input logic [FW-1:0] d);
      @(negedge clk);
      rbase = rises;
      bus.data_in = d;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   logic [FW-1:0] fa, fb, fc, fd, fx, fy;
   int b_rise, b_cs, b_done;

   initial begin
      fa = make_frame(128'h00112233445566778899aabbccddeeff, 8'h10,
                      256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000);
      fb = make_frame(128'hfedcba98765432100123456789abcdef, 8'h18,
                      256'h0f1e2d3c4b5a69788796a5b4c3d2e1f0_0123456789abcdef_0000000000000000);
      fc = make_frame(128'h8000000000000000000000000000000a, 8'h20,
                      256'hcafebabe_deadbeef_13579bdf_2468ace0_a5a5a5a5_5a5a5a5a_ffffffff_00000001);
      fd = make_frame(128'hdeadbeef_01234567_89abcdef_c0ffee00, 8'h5a,
                      256'h80000000_00000000_00000000_00000000_00000000_00000000_00000000_00000001);
      fx = make_frame(128'h0123456789abcdef0123456789abcdef, 8'h10, 256'h1);
      fy = make_frame(128'hffffffffffffffffffffffffffffffff, 8'hff, {256{1'b1}});
      bus.start = 1'b0;
      bus.data_in = '0;
      #2 reset = 1'b0;
      #1;
      chk("rst_cs", FW'(bus.cs), FW'(1));
      chk("rst_sclk", FW'(bus.sclk), FW'(0));
      chk("rst_mosi", FW'(bus.mosi), FW'(0));
      chk("rst_buzy", FW'(bus.buzy), FW'(0));
      chk("rst_done", FW'(bus.done), FW'(0));
      chk("rst_data_out", bus.data_out, '0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_cs", FW'(bus.cs), FW'(1));

      // loopback frame with timing checks
      mode = 0;
      b_cs = cs_low; b_done = dones;
      pulse_start(fa);
      b_rise = rbase;
      chk("a_cs_fall", FW'(bus.cs), FW'(0));
      chk("a_buzy", FW'(bus.buzy), FW'(1));
      chk("a_mosi_first", FW'(bus.mosi), FW'(fa[FW-1]));
      wait_done("a_done_seen");
      chk("a_data_out", bus.data_out, fa);
      chk("a_done_cs", FW'(bus.cs), FW'(1));
      chk("a_done_sclk", FW'(bus.sclk), FW'(0));
      chk("a_done_buzy", FW'(bus.buzy), FW'(0));
      chk("a_rises", FW'(rises - b_rise), FW'(FW));
      chk("a_cs_low_cycles", FW'(cs_low - b_cs), FW'(XFER_CYC));
      @(negedge clk);
      chk("a_done_one_cycle", FW'(bus.done), FW'(0));
      chk("a_done_count", FW'(dones - b_done), FW'(1));
      chk("a_back_idle_cs", FW'(bus.cs), FW'(1));
      chk("a_hold_data_out", bus.data_out, fa);

      // miso tied high, then low, then an MSB-first pattern
      mode = 1; cval = 1'b1;
      pulse_start(fb);
      wait_done("ones_done_seen");
      chk("ones_data_out", bus.data_out, {FW{1'b1}});
      cval = 1'b0;
      pulse_start(fb);
      wait_done("zeros_done_seen");
      chk("zeros_data_out", bus.data_out, '0);
      pat = fd;
      mode = 2;
      pulse_start(fc);
      wait_done("pat_done_seen");
      chk("pat_data_out", bus.data_out, fd);

      // back-to-back: start held from each DONE cycle
      mode = 0;
      pulse_start(fa);
      bus.start = 1'b1;
      wait_done("b2b1_done_seen");
      chk("b2b1_data_out", bus.data_out, fa);
      chk("b2b1_gap_cs", FW'(bus.cs), FW'(1));
      bus.data_in = fb;
      b_cs = cs_low;
      @(negedge clk);
      chk("b2b2_cs_fall", FW'(bus.cs), FW'(0));
      wait_done("b2b2_done_seen");
      chk("b2b2_data_out", bus.data_out, fb);
      chk("b2b2_gap_cs", FW'(bus.cs), FW'(1));
      chk("b2b2_cs_low_cycles", FW'(cs_low - b_cs), FW'(XFER_CYC));
      bus.data_in = fc;
      @(negedge clk);
      chk("b2b3_cs_fall", FW'(bus.cs), FW'(0));
      wait_done("b2b3_done_seen");
      chk("b2b3_data_out", bus.data_out, fc);
      chk("b2b3_gap_cs", FW'(bus.cs), FW'(1));
      bus.start = 1'b0;
      @(negedge clk);
      chk("b2b_end_idle", FW'(bus.cs), FW'(1));

      // start pulse mid-transfer is ignored
      b_cs = cs_low;
      pulse_start(fx);
      repeat (500) @(negedge clk);
      bus.data_in = fy;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("mid_start_still_buzy", FW'(bus.buzy), FW'(1));
      wait_done("mid_done_seen");
      chk("mid_data_out", bus.data_out, fx);
      chk("mid_cs_low_cycles", FW'(cs_low - b_cs), FW'(XFER_CYC));

      // reset at bit 200 aborts the frame
      pulse_start(fb);
      begin
         bit hit;
         hit = 0;
         for (int i = 0; i < XFER_CYC && !hit; i++) begin
            @(negedge clk);
            hit = (rises - rbase) == 201;
         end
         chk("abort_bit200_reached", FW'(hit), FW'(1));
      end
      #2 reset = 1'b0;
      #1;
      chk("abort_cs", FW'(bus.cs), FW'(1));
      chk("abort_sclk", FW'(bus.sclk), FW'(0));
      chk("abort_data_out", bus.data_out, '0);
      chk("abort_buzy", FW'(bus.buzy), FW'(0));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      b_done = dones;
      repeat (XFER_CYC + 50) @(negedge clk);
      chk("abort_no_done", FW'(dones - b_done), FW'(0));
      chk("abort_idle_cs", FW'(bus.cs), FW'(1));
      chk("abort_data_out_held", bus.data_out, '0);
      pulse_start(fc);
      wait_done("post_done_seen");
      chk("post_data_out", bus.data_out, fc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
